// File: rtl/prog_loader.sv
// Boot-time stream loader: parses ID/count/address sections from a byte stream,
// assembles big-endian words, writes them to on-chip memories and gates the CPU reset.
module prog_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int NUM_MEM = 2
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               reload,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_written
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = 4;

  typedef enum logic [2:0] {
    S_HDR_ID, S_CNT_H, S_CNT_L, S_ADDR_H, S_ADDR_L, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          id_q, id_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                s_ready_q, s_ready_d;
  logic [NUM_MEM-1:0]  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [15:0]         ww_q, ww_d;
  logic [DATA_W-1:0]   word_nxt;
  logic                accept;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                 input logic [7:0] b);
    return DATA_W'({word, b});
  endfunction

  function automatic logic id_valid(input logic [7:0] id);
    return {1'b0, id} < 9'(NUM_MEM);
  endfunction

  function automatic logic [NUM_MEM-1:0] id_onehot(input logic [7:0] id);
    return NUM_MEM'(1) << id;
  endfunction

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    ww_d        = ww_q;
    accept      = s_valid & s_ready_q;
    word_nxt    = shift_in(word_q, s_data);

    case (state_q)
      S_HDR_ID: if (accept) begin
        id_d = s_data;
        if (s_data == 8'hFF) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end else if (!id_valid(s_data)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d = S_CNT_H;
        end
      end
      S_CNT_H: if (accept) begin
        cnt_d   = {s_data, cnt_q[7:0]};
        state_d = S_CNT_L;
      end
      S_CNT_L: if (accept) begin
        cnt_d   = {cnt_q[15:8], s_data};
        state_d = S_ADDR_H;
      end
      S_ADDR_H: if (accept) begin
        addr_hi_d = s_data;
        state_d   = S_ADDR_L;
      end
      S_ADDR_L: if (accept) begin
        // Only the low ADDR_W bits of the 16-bit start address are meaningful.
        addr_d  = ADDR_W'({addr_hi_q, s_data});
        bcnt_d  = '0;
        state_d = (cnt_q == 16'd0) ? S_HDR_ID : S_DATA;
      end
      S_DATA: if (accept) begin
        if (bcnt_q == BC_W'(BYTES - 1)) begin
          mem_we_d    = id_onehot(id_q);
          mem_addr_d  = addr_q;
          mem_wdata_d = word_nxt;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - 16'd1;
          ww_d        = ww_q + 16'd1;
          bcnt_d      = '0;
          if (cnt_q == 16'd1) state_d = S_HDR_ID;
        end else begin
          word_d = word_nxt;
          bcnt_d = bcnt_q + BC_W'(1);
        end
      end
      S_DONE: if (reload) begin
        state_d     = S_HDR_ID;
        done_d      = 1'b0;
        cpu_reset_d = 1'b1;
        ww_d        = '0;
      end
      S_ERR: ;
      default: state_d = S_ERR;
    endcase

    s_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HDR_ID;
      id_q        <= '0;
      cnt_q       <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ww_q        <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ww_q        <= ww_d;
    end
  end

  // Assembly register is pure data; a reset clears bcnt_q so stale bytes shift out.
  always_ff @(posedge clk_in) begin
    word_q <= word_d;
  end

  assign s_ready       = s_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as sections are sent
// and a negedge monitor pops and compares each mem_we pulse.
module tb_prog_loader;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        reload = 1'b0;
  logic [1:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset, done, error;
  logic [15:0] words_written;

  prog_loader #(.DATA_W(32), .ADDR_W(11), .NUM_MEM(2)) dut (
    .clk_in(clk_in), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]  we;
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_ww = 0;
  bit          gaps_en = 0;
  logic [31:0] wbuf [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every observed write strobe must match the oldest expected write.
  always @(negedge clk_in) begin
    if (reset === 1'b1 && mem_we !== 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write we=%b addr=%h data=%h required=no_write",
                 mem_we, mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_we", 64'(mem_we), 64'(e.we));
        chk("write_addr", 64'(mem_addr), 64'(e.addr));
        chk("write_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (gaps_en) begin
      while ($urandom % 2 == 0) begin
        s_valid = 1'b0;
        @(negedge clk_in);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    if (gaps_en) chk("ready_during_gaps", 64'(s_ready), 64'd1);
    while (!s_ready && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
    @(negedge clk_in);
    s_valid = 1'b0;
  endtask

  // Reference model: section words land at consecutive addresses modulo 2^11.
  task automatic send_section(input int id, input int cnt, input int addr);
    wr_t e;
    send_byte(8'(id));
    send_byte(8'(cnt >> 8));
    send_byte(8'(cnt));
    send_byte(8'(addr >> 8));
    send_byte(8'(addr));
    for (int w = 0; w < cnt; w++) begin
      e.we   = 2'(1 << id);
      e.addr = 11'((addr + w) % 2048);
      e.data = wbuf[w];
      exp_q.push_back(e);
      exp_ww = (exp_ww + 1) % 65536;
      for (int b = 3; b >= 0; b--) send_byte(8'(wbuf[w] >> (8 * b)));
    end
  endtask

  task automatic terminate_and_check(input string tag);
    send_byte(8'hFF);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    chk({tag, "_ready_low"}, 64'(s_ready), 64'd0);
    chk({tag, "_words"}, 64'(words_written), 64'(exp_ww));
    repeat (2) @(negedge clk_in);
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk_in);
    reload = 1'b0;
    exp_ww = 0;
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("reload_ready", 64'(s_ready), 64'd1);
    chk("reload_words", 64'(words_written), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_words"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk_in);
    chk("ready_after_release", 64'(s_ready), 64'd1);

    // Basic IRAM load
    wbuf[0] = 32'h20080005; wbuf[1] = 32'h2009000A;
    send_section(0, 2, 16'h0004);
    terminate_and_check("basic");
    do_reload();

    // Two sections, second has zero count
    wbuf[0] = 32'hDEADBEEF;
    send_section(1, 1, 16'h0000);
    send_section(0, 0, 16'h0000);
    terminate_and_check("two_sec");
    do_reload();

    // Address wrap
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    send_section(0, 2, 16'h07FF);
    terminate_and_check("wrap");
    do_reload();

    // Random valid gaps on the basic scenario
    gaps_en = 1;
    wbuf[0] = 32'h20080005; wbuf[1] = 32'h2009000A;
    send_section(0, 2, 16'h0004);
    terminate_and_check("gaps");
    do_reload();

    // Random sections, random addresses (upper bits ignored), random gaps
    for (int s = 0; s < 6; s++) begin
      int id, cnt, addr;
      id   = int'($urandom % 2);
      cnt  = int'($urandom_range(0, 5));
      addr = int'($urandom % 65536);
      for (int w = 0; w < cnt; w++) wbuf[w] = $urandom;
      gaps_en = ($urandom % 2) == 1;
      send_section(id, cnt, addr);
    end
    gaps_en = 0;
    terminate_and_check("random");
    do_reload();

    // Invalid ID
    send_byte(8'h05);
    chk("err_flag", 64'(error), 64'd1);
    chk("err_ready", 64'(s_ready), 64'd0);
    chk("err_cpu_reset", 64'(cpu_reset), 64'd1);
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'($urandom);
      reload = (i == 4);
      @(negedge clk_in);
    end
    s_valid = 1'b0;
    reload  = 1'b0;
    chk("err_sticky", 64'(error), 64'd1);
    chk("err_ready_sticky", 64'(s_ready), 64'd0);
    chk("err_no_done", 64'(done), 64'd0);
    chk("err_cpu_reset_sticky", 64'(cpu_reset), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_values("err_clear");
    @(negedge clk_in);
    reset = 1'b1;
    exp_ww = 0;
    @(negedge clk_in);

    // Reset mid-word: partial word must never be written
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b0;
    #1;
    check_reset_values("midword");
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    wbuf[0] = 32'h13572468;
    send_section(0, 1, 16'h0003);
    terminate_and_check("after_abort");
    do_reload();

    repeat (3) @(negedge clk_in);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program/data preloader for the single-cycle SoC. It accepts a byte stream over a valid/ready handshake and assembles big-endian words. The words are written into up to NUM_MEM on-chip memories (instruction RAM, data RAM, ...) through a shared write port. The CPU core is held in reset until a terminator is received. This replaces simulation-only memory initialisation with a synthesizable boot path usable on FPGA and in regression benches.

## Interface
Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8, 8..64
- ADDR_W, 11, word address width; 1..16
- NUM_MEM, 2, number of target memories; 1..254 (id 0 = instruction RAM, id 1 = data RAM)

Ports:
- clk_in  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  loader can accept a byte; transfer when s_valid & s_ready at a rising edge
- reload  in  1  single-cycle request to restart loading; honoured only in DONE
- mem_we  out  NUM_MEM  one-hot write strobe, bit i selects memory i
- mem_addr  out  ADDR_W  word write address
- mem_wdata  out  DATA_W  write data
- cpu_reset  out  1  active-high reset to the CPU core; 1 while loading
- done  out  1  load complete, CPU released
- error  out  1  sticky: invalid memory id received
- words_written  out  16  count of words written since last reset/reload; wraps at 2^16

## Operation
- Stream format is a sequence of sections. Each section is:
  - ID byte
  - CNT_H, CNT_L: 16-bit word count
  - ADDR_H, ADDR_L: 16-bit start word address; only the low ADDR_W bits are used
  - CNT × (DATA_W/8) data bytes, most significant byte first
- ID 0xFF is the terminator: no further bytes are consumed; enter DONE.
- ID ≥ NUM_MEM and ≠ 0xFF: enter ERR. ERR is left only by reset; cpu_reset stays 1.
- States and transitions:
  - HDR_ID → CNT_H → CNT_L → ADDR_H → ADDR_L → DATA → HDR_ID. Each header step advances on one accepted byte.
  - CNT = 0: ADDR_L → HDR_ID directly; no writes.
  - DATA: shift each byte into the word assembly register. After DATA_W/8 bytes, issue one write. Then increment the address modulo 2^ADDR_W (wraps to 0) and decrement the remaining count. When the count reaches 0, return to HDR_ID.
  - DONE: reload=1 → HDR_ID and cpu_reset=1. reload is ignored in all other states.
- s_ready = 1 in HDR_ID, CNT_*, ADDR_*, DATA; 0 in DONE and ERR.
- Sections may target the same memory repeatedly. Later writes to the same address overwrite earlier ones.
- words_written increments once per issued write and is cleared on reload.

## Timing
- Reset values:
  - s_ready=0 while reset low, 1 from the first edge after release
  - mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_reset=1, done=0, error=0, words_written=0
  - state HDR_ID
- Write latency: the last byte of a word is accepted at edge k. mem_we/mem_addr/mem_wdata are registered and valid for exactly cycle k..k+1; the memory samples at edge k+1.
- mem_we is a one-cycle pulse per word. The loader never stalls s_ready for writes; full throughput is 1 byte/cycle.
- Terminator accepted at edge k: done=1 and cpu_reset=0 from edge k. Any pending write from edge k-1 completes at edge k, before the CPU leaves reset.
- Invalid ID accepted at edge k: error=1 and s_ready=0 from edge k.
- reload sampled at edge k in DONE: done=0, cpu_reset=1, s_ready=1, words_written=0 from edge k.
- s_valid=0 mid-word or mid-header holds all state; gaps of any length are allowed.
- Asynchronous reset mid-section aborts immediately. A partially assembled word is discarded and never written; mem_we drops asynchronously.

## Test plan
- Load IRAM (ID 0), CNT=2, ADDR=0x0004, data 0x20080005, 0x2009000A, then 0xFF. Required: mem_we=01 twice; addr 4, 5 with those words; words_written=2; done=1; cpu_reset=0 one edge after 0xFF.
- Two sections: ID 1, CNT=1, ADDR=0, 0xDEADBEEF; then ID 0, CNT=0; then 0xFF. Required: a single mem_we=10 pulse at addr 0 with 0xDEADBEEF; no write for the CNT=0 section.
- Address wrap with ADDR_W=11: ID 0, CNT=2, ADDR=0x07FF. Required: writes at 0x7FF then 0x000.
- Random s_valid gaps (50% duty) on the first scenario. Required: identical writes and values, one mem_we per word, s_ready=1 throughout.
- Invalid ID 0x05 with NUM_MEM=2. Required: error=1, s_ready=0, cpu_reset stays 1; later bytes and reload ignored; cleared only by reset low.
- Reset low mid-word after 2 of 4 data bytes. Required: no mem_we, all outputs at reset values. A reload pulse in DONE after a full load re-arms cpu_reset=1 and clears words_written to 0.
